pixel_stream_loader: RTL and testbench

Upstream feeder for the colorshield display controller. Converts a byte stream (R, G, B per pixel, 64 pixels per frame, start-of-frame marked) into addressed 24-bit pixel writes. Buffers completed pixels in a small show-ahead FIFO and drains them through the controller's write_en/ready handshake. Decouples the byte source from the controller's long PAINT phases, during which ready is low.

---
 rtl/pixel_stream_loader_if.sv | 21 ++
 rtl/pixel_stream_loader.sv | 141 ++++++++++++++
 tb/tb_pixel_stream_loader.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/pixel_stream_loader_if.sv
// Handshake bundles for the pixel stream loader: the byte stream it consumes
// and the pixel-write port it drives toward the display controller.
interface byte_stream_if;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_sof;
  logic       in_ready;

  modport master (output in_data, in_valid, in_sof, input in_ready);
  modport slave  (input in_data, in_valid, in_sof, output in_ready);
endinterface

interface pixel_write_if;
  logic        shield_ready;
  logic        write_en;
  logic [5:0]  pixel_addr;
  logic [23:0] pixel_value;

  modport master (output write_en, pixel_addr, pixel_value, input shield_ready);
  modport slave  (input write_en, pixel_addr, pixel_value, output shield_ready);
endinterface

// File: rtl/pixel_stream_loader.sv
// Packs an R,G,B byte stream into addressed 24-bit pixel writes, buffered in a
// small show-ahead FIFO so the source keeps flowing while the controller paints.
module pixel_stream_loader #(
  parameter int unsigned FIFO_AW = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  byte_stream_if.slave   in_if,
  pixel_write_if.master  wr_if,
  output logic           frame_done,
  output logic           sync_err
);

  localparam int unsigned DEPTH = 1 << FIFO_AW;

  localparam logic [0:0] ST_HUNT = 1'b0;
  localparam logic [0:0] ST_LOAD = 1'b1;

  typedef struct packed {
    logic [5:0]  addr;
    logic [23:0] rgb;
  } pixel_t;

  logic [0:0]         state_q, state_d;
  logic [1:0]         phase_q, phase_d;
  logic [5:0]         addr_cnt_q, addr_cnt_d;
  logic [7:0]         r_q, r_d;
  logic [7:0]         g_q, g_d;
  logic               sync_err_q, sync_err_d;
  logic               frame_done_q;

  pixel_t             mem_q [DEPTH];
  pixel_t             last_q;
  logic [FIFO_AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [FIFO_AW:0]   count_q;

  logic               fifo_full, fifo_empty;
  logic               accept, push, pop;
  pixel_t             push_data, head;

  assign fifo_full  = (count_q == (FIFO_AW+1)'(DEPTH));
  assign fifo_empty = (count_q == '0);
  assign accept     = in_if.in_valid & ~fifo_full;
  assign pop        = ~fifo_empty & wr_if.shield_ready;

  // An empty FIFO keeps presenting the last popped pixel rather than stale slots.
  assign head = fifo_empty ? last_q : mem_q[rd_ptr_q];

  assign in_if.in_ready    = ~fifo_full;
  assign wr_if.write_en    = ~fifo_empty;
  assign wr_if.pixel_addr  = head.addr;
  assign wr_if.pixel_value = head.rgb;
  assign frame_done        = frame_done_q;
  assign sync_err          = sync_err_q;

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_d    = state_q;
    phase_d    = phase_q;
    addr_cnt_d = addr_cnt_q;
    r_d        = r_q;
    g_d        = g_q;
    sync_err_d = sync_err_q;
    push       = 1'b0;
    push_data  = '{addr: addr_cnt_q, rgb: {r_q, g_q, in_if.in_data}};

    if (accept) begin
      if (in_if.in_sof) begin
        // A start-of-frame always restarts at pixel 0; mid-pixel or mid-frame is an error.
        if (state_q == ST_LOAD && (phase_q != 2'd0 || addr_cnt_q != 6'd0)) begin
          sync_err_d = 1'b1;
        end
        state_d    = ST_LOAD;
        r_d        = in_if.in_data;
        phase_d    = 2'd1;
        addr_cnt_d = 6'd0;
      end else if (state_q == ST_LOAD) begin
        case (phase_q)
          2'd0: begin
            r_d     = in_if.in_data;
            phase_d = 2'd1;
          end
          2'd1: begin
            g_d     = in_if.in_data;
            phase_d = 2'd2;
          end
          default: begin
            push       = 1'b1;
            phase_d    = 2'd0;
            addr_cnt_d = addr_cnt_q + 6'd1;
          end
        endcase
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_HUNT;
      phase_q      <= 2'd0;
      addr_cnt_q   <= 6'd0;
      r_q          <= 8'd0;
      g_q          <= 8'd0;
      sync_err_q   <= 1'b0;
      frame_done_q <= 1'b0;
      last_q       <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
    end else begin
      state_q      <= state_d;
      phase_q      <= phase_d;
      addr_cnt_q   <= addr_cnt_d;
      r_q          <= r_d;
      g_q          <= g_d;
      sync_err_q   <= sync_err_d;
      frame_done_q <= pop && (head.addr == 6'd63);
      if (pop) begin
        last_q   <= head;
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      if (push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // NOTE: storage is not reset; occupancy and the empty-head mux keep stale entries invisible.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

endmodule

// File: tb/tb_pixel_stream_loader.sv
// Randomized bench for pixel_stream_loader, checked every cycle against a
// transaction-level model (byte queue -> pixel queue -> controller pops).
module tb_pixel_stream_loader;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  logic frame_done;
  logic sync_err;

  always #5 clk = ~clk;

  byte_stream_if bs ();
  pixel_write_if pw ();

  pixel_stream_loader #(.FIFO_AW(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_if      (bs),
    .wr_if      (pw),
    .frame_done (frame_done),
    .sync_err   (sync_err)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Reference model: bytes gather into pixels, pixels queue for the controller.
  typedef struct {
    logic [5:0]  addr;
    logic [23:0] rgb;
  } pix_t;

  pix_t        exp_q[$];
  logic [7:0]  pend[$];
  bit          synced;
  int          pix_idx;
  bit          err_m;
  bit          fd_m;
  logic [5:0]  last_a;
  logic [23:0] last_v;

  int cyc        = 0;
  int ready_mode = 0;  // 0: always ready, 1: never, 2: toggle, 3: random
  int gap_pct    = 0;
  int fd_count   = 0;

  function automatic void model_reset();
    exp_q.delete();
    pend.delete();
    synced  = 1'b0;
    pix_idx = 0;
    err_m   = 1'b0;
    fd_m    = 1'b0;
    last_a  = '0;
    last_v  = '0;
  endfunction

  function automatic void model_byte(input logic [7:0] d, input bit sof);
    pix_t p;
    if (sof) begin
      if (synced && (pend.size() != 0 || pix_idx != 0)) err_m = 1'b1;
      pend.delete();
      pend.push_back(d);
      pix_idx = 0;
      synced  = 1'b1;
    end else if (synced) begin
      pend.push_back(d);
      if (pend.size() == 3) begin
        p.addr = 6'(pix_idx);
        p.rgb  = {pend[0], pend[1], pend[2]};
        exp_q.push_back(p);
        pend.delete();
        pix_idx = (pix_idx + 1) % 64;
      end
    end
  endfunction

  task automatic step(output bit acc);
    bit         v, s, r, pop;
    logic [7:0] d;
    logic [5:0] ea;
    logic [23:0] ev;
    case (ready_mode)
      0:       pw.shield_ready = 1'b1;
      1:       pw.shield_ready = 1'b0;
      2:       pw.shield_ready = cyc[0];
      default: pw.shield_ready = 1'($urandom_range(1));
    endcase
    v   = bs.in_valid;
    s   = bs.in_sof;
    d   = bs.in_data;
    r   = pw.shield_ready;
    acc = v && (exp_q.size() < 4);
    pop = (exp_q.size() > 0) && r;
    @(posedge clk);
    #1;
    cyc++;
    fd_m = 1'b0;
    if (pop) begin
      pix_t p;
      p      = exp_q.pop_front();
      last_a = p.addr;
      last_v = p.rgb;
      fd_m   = (p.addr == 6'd63);
    end
    if (acc) model_byte(d, s);
    if (frame_done) fd_count++;
    if (exp_q.size() > 0) begin
      ea = exp_q[0].addr;
      ev = exp_q[0].rgb;
    end else begin
      ea = last_a;
      ev = last_v;
    end
    check("write_en", 32'(pw.write_en), 32'(exp_q.size() > 0));
    check("in_ready", 32'(bs.in_ready), 32'(exp_q.size() < 4));
    check("pixel_addr", 32'(pw.pixel_addr), 32'(ea));
    check("pixel_value", 32'(pw.pixel_value), 32'(ev));
    check("frame_done", 32'(frame_done), 32'(fd_m));
    check("sync_err", 32'(sync_err), 32'(err_m));
  endtask

  task automatic idle(input int n);
    bit acc;
    bs.in_valid = 1'b0;
    bs.in_sof   = 1'b0;
    for (int i = 0; i < n; i++) begin
      bs.in_data = 8'($urandom);
      step(acc);
    end
  endtask

  task automatic send_byte(input logic [7:0] d, input bit sof);
    bit acc;
    int guard = 0;
    if (gap_pct != 0 && $urandom_range(99) < gap_pct) idle(1);
    bs.in_valid = 1'b1;
    bs.in_data  = d;
    bs.in_sof   = sof;
    do begin
      step(acc);
      guard++;
    end while (!acc && guard < 1000);
    if (!acc) check("send_timeout", 32'd0, 32'd1);
    bs.in_valid = 1'b0;
    bs.in_sof   = 1'b0;
  endtask

  task automatic drain();
    int guard = 0;
    bit acc;
    bs.in_valid = 1'b0;
    bs.in_sof   = 1'b0;
    while (exp_q.size() > 0 && guard < 2000) begin
      step(acc);
      guard++;
    end
    if (exp_q.size() > 0) check("drain_timeout", 32'(exp_q.size()), 32'd0);
    idle(2);
  endtask

  // Reset is asserted between clock edges; outputs must react before any edge.
  task automatic do_reset();
    bs.in_valid = 1'b0;
    bs.in_sof   = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check("rst_write_en", 32'(pw.write_en), 32'd0);
    check("rst_in_ready", 32'(bs.in_ready), 32'd1);
    check("rst_addr", 32'(pw.pixel_addr), 32'd0);
    check("rst_value", 32'(pw.pixel_value), 32'd0);
    check("rst_frame_done", 32'(frame_done), 32'd0);
    check("rst_sync_err", 32'(sync_err), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bs.in_valid     = 1'b0;
    bs.in_sof       = 1'b0;
    bs.in_data      = 8'd0;
    pw.shield_ready = 1'b1;
    model_reset();
    do_reset();

    // Counting frame: pixel k = {3k, 3k+1, 3k+2}
    ready_mode = 0;
    fd_count   = 0;
    for (int j = 0; j < 192; j++) send_byte(8'(j), j == 0);
    drain();
    check("frame1_done_count", 32'(fd_count), 32'd1);

    // Bytes before the first sof are dropped
    do_reset();
    for (int j = 0; j < 6; j++) send_byte(8'($urandom), 1'b0);
    check("hunt_no_write", 32'(pw.write_en), 32'd0);
    for (int j = 0; j < 192; j++) send_byte(8'($urandom), j == 0);
    drain();

    // Backpressure: four pixels fill the FIFO and the head holds
    do_reset();
    ready_mode = 1;
    for (int j = 0; j < 12; j++) send_byte(8'(j), j == 0);
    check("full_in_ready", 32'(bs.in_ready), 32'd0);
    check("full_write_en", 32'(pw.write_en), 32'd1);
    check("full_addr", 32'(pw.pixel_addr), 32'd0);
    idle(4);
    ready_mode = 0;
    idle(1);
    check("ready_after_pop", 32'(bs.in_ready), 32'd1);
    for (int j = 12; j < 192; j++) send_byte(8'(j), 1'b0);
    drain();

    // Restart at byte 100 of a frame, then a complete frame
    for (int j = 0; j < 99; j++) send_byte(8'($urandom), j == 0);
    for (int j = 0; j < 192; j++) send_byte(8'($urandom), j == 0);
    drain();
    check("sync_err_sticky", 32'(sync_err), 32'd1);

    // Back-to-back frames with the controller ready every other cycle
    do_reset();
    ready_mode = 2;
    fd_count   = 0;
    for (int j = 0; j < 576; j++) send_byte(8'($urandom), (j % 192) == 0);
    drain();
    check("b2b_done_count", 32'(fd_count), 32'd3);
    check("b2b_no_sync_err", 32'(sync_err), 32'd0);

    // Reset mid-frame with three pixels buffered
    ready_mode = 1;
    for (int j = 0; j < 10; j++) send_byte(8'($urandom), j == 0);
    check("pre_rst_write_en", 32'(pw.write_en), 32'd1);
    check("pre_rst_addr", 32'(pw.pixel_addr), 32'd0);
    do_reset();
    ready_mode = 0;
    for (int j = 0; j < 6; j++) send_byte(8'($urandom), 1'b0);
    check("post_rst_write_en", 32'(pw.write_en), 32'd0);

    // Random traffic: gaps, stray sofs, varied controller readiness
    do_reset();
    gap_pct = 20;
    for (int j = 0; j < 3000; j++) begin
      if (j % 200 == 0) begin
        int m;
        m = int'($urandom_range(2));
        ready_mode = (m == 0) ? 0 : m + 1;
      end
      send_byte(8'($urandom), ((j % 192) == 0) || ($urandom_range(99) < 2));
    end
    ready_mode = 0;
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
